// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - iterative MIPS multiply/divide unit with HI/LO registers
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t               state_q;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     m_q;
    // Multiply: {partial product high, multiplier/low bits}; divide: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 neg_q;
    logic                 rneg_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 dbz_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic                 op_is_div;
    logic                 op_is_signed;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shifted;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   prod_fixed;
    logic                 div_zero;
    logic [WIDTH-1:0]     hi_d;
    logic [WIDTH-1:0]     lo_d;

    assign op_is_div    = op_q[1];
    assign op_is_signed = ~op_q[0];
    assign div_zero     = op_is_div && (b_q == '0);

    // Operand magnitudes and signs, taken from the latched operands during PREP
    always_comb begin
        sign_a = op_is_signed & a_q[WIDTH-1];
        sign_b = op_is_signed & b_q[WIDTH-1];
        mag_a  = sign_a ? (~a_q + 1'b1) : a_q;
        mag_b  = sign_b ? (~b_q + 1'b1) : b_q;
    end

    // One shift-add (multiply) or restoring-subtract (divide) step per ITER cycle
    always_comb begin
        mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        div_shifted = acc_q[2*WIDTH-1:WIDTH-1];
        div_trial   = div_shifted - {1'b0, m_q};
        acc_d       = acc_q;
        if (!op_is_div) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
            acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {div_shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    // Final sign correction and divide-by-zero substitution for the FIX edge
    always_comb begin
        prod_fixed = neg_q ? (~acc_q + 1'b1) : acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        if (!op_is_div) begin
            hi_d = prod_fixed[2*WIDTH-1:WIDTH];
            lo_d = prod_fixed[WIDTH-1:0];
        end else if (div_zero) begin
            hi_d = a_q;
            lo_d = {WIDTH{1'b1}};
        end else begin
            lo_d = neg_q  ? (~acc_q[WIDTH-1:0] + 1'b1)       : acc_q[WIDTH-1:0];
            hi_d = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
        end
    end

    // Control FSM with registered Busy/Done and the architectural HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        // Start wins over a simultaneous MTHI/MTLO
                        a_q     <= OperandA;
                        b_q     <= OperandB;
                        op_q    <= Op;
                        busy_q  <= 1'b1;
                        state_q <= S_PREP;
                    end else begin
                        if (HiWrite) hi_q <= WriteData;
                        if (LoWrite) lo_q <= WriteData;
                    end
                end
                S_PREP: begin
                    m_q     <= mag_b;
                    acc_q   <= {{WIDTH{1'b0}}, mag_a};
                    neg_q   <= sign_a ^ sign_b;
                    rneg_q  <= sign_a;
                    cnt_q   <= CW'(WIDTH - 1);
                    state_q <= S_ITER;
                end
                S_ITER: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    dbz_q   <= div_zero;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - directed vector bench for mips_muldiv_unit
module tb_mips_muldiv_unit;

    localparam int W = 32;
    localparam int LAT = W + 2;
    localparam int NV = 14;

    logic         clk = 1'b0;
    logic         reset;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] OperandA;
    logic [W-1:0] OperandB;
    logic         HiWrite;
    logic         LoWrite;
    logic [W-1:0] WriteData;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;
    logic         DivByZero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .Op        (Op),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .HiWrite   (HiWrite),
        .LoWrite   (LoWrite),
        .WriteData (WriteData),
        .Busy      (Busy),
        .Done      (Done),
        .Hi        (Hi),
        .Lo        (Lo),
        .DivByZero (DivByZero)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Issue one op and wait for Done; called right after the previous Done so ops run back to back
    task automatic run_op(input vec_t v);
        int  k;
        logic busy_ok;
        Op       = v.op;
        OperandA = v.a;
        OperandB = v.b;
        Start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Start    = 1'b0;
        OperandA = ~v.a;
        OperandB = ~v.b;
        Op       = ~v.op;
        check({v.name, " busy_after_start"}, 64'(Busy), 64'd1);
        check({v.name, " done_low_after_start"}, 64'(Done), 64'd0);
        k = 0;
        busy_ok = 1'b1;
        while (!Done && k < 200) begin
            @(negedge clk);
            k++;
            if (!Done && !Busy) busy_ok = 1'b0;
        end
        check({v.name, " latency"}, 64'(k), 64'(LAT));
        check({v.name, " busy_held"}, 64'(busy_ok), 64'd1);
        check({v.name, " busy_clear_on_done"}, 64'(Busy), 64'd0);
        check({v.name, " hi"}, 64'(Hi), 64'(v.hi));
        check({v.name, " lo"}, 64'(Lo), 64'(v.lo));
        check({v.name, " dbz"}, 64'(DivByZero), 64'(v.dbz));
    endtask

    initial begin
        int k;
        int done_cnt;
        int busy_cnt;

        vecs[0]  = '{"multu_max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{"mult_m3x5",   2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{"div_m7d2",    2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{"divu_7d2",    2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
        vecs[4]  = '{"div_by0",     2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{"divu_10d3",   2'b11, 32'h0000000A, 32'h00000003, 32'h00000001, 32'h00000003, 1'b0};
        vecs[6]  = '{"div_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[7]  = '{"mult_minsq",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[8]  = '{"mult_7xm1",   2'b00, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};
        vecs[9]  = '{"div_7dm2",    2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[10] = '{"divu_0d0",    2'b11, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{"multu_sh4",   2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        vecs[12] = '{"divu_max1",   2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[13] = '{"div_m8dm3",   2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};

        reset     = 1'b1;
        Start     = 1'b0;
        Op        = 2'b00;
        OperandA  = '0;
        OperandB  = '0;
        HiWrite   = 1'b0;
        LoWrite   = 1'b0;
        WriteData = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(Busy), 64'd0);
        check("reset done", 64'(Done), 64'd0);
        check("reset hi", 64'(Hi), 64'd0);
        check("reset lo", 64'(Lo), 64'd0);
        check("reset dbz", 64'(DivByZero), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i]);
        end
        @(negedge clk);
        check("done_one_cycle", 64'(Done), 64'd0);

        // MTLO in IDLE lands on the next edge; Hi untouched
        LoWrite   = 1'b1;
        WriteData = 32'h00005555;
        @(negedge clk);
        LoWrite   = 1'b0;
        check("mtlo lo", 64'(Lo), 64'h5555);
        check("mtlo hi_kept", 64'(Hi), 64'hFFFFFFFE);

        // Second Start during ITER is ignored; MTHI during Busy is dropped
        Op = 2'b01; OperandA = 32'd6; OperandB = 32'd7; Start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        k = 0;
        while (!Done && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 5) begin
                Start = 1'b1; Op = 2'b11; OperandA = 32'd100; OperandB = 32'd0;
            end else if (k == 6) begin
                Start = 1'b0;
            end else if (k == 10) begin
                HiWrite = 1'b1; WriteData = 32'h0000AAAA;
            end else if (k == 11) begin
                HiWrite = 1'b0;
                check("mthi_busy_dropped", 64'(Hi), 64'hFFFFFFFE);
            end
        end
        check("restart latency", 64'(k), 64'(LAT));
        check("restart hi", 64'(Hi), 64'd0);
        check("restart lo", 64'(Lo), 64'd42);
        check("restart dbz", 64'(DivByZero), 64'd0);
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done) done_cnt++;
            if (Busy) busy_cnt++;
        end
        check("no_queued_done", 64'(done_cnt), 64'd0);
        check("no_queued_busy", 64'(busy_cnt), 64'd0);

        // Start and MTHI together: Start wins
        Op = 2'b01; OperandA = 32'h00010001; OperandB = 32'h00030000; Start = 1'b1;
        HiWrite = 1'b1; WriteData = 32'h0000BEEF;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0; HiWrite = 1'b0;
        check("start_wins hi", 64'(Hi), 64'd0);
        k = 0;
        while (!Done && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("start_wins latency", 64'(k), 64'(LAT));
        check("start_wins prod_hi", 64'(Hi), 64'h3);
        check("start_wins prod_lo", 64'(Lo), 64'h00030000);

        // Reset mid-iteration discards the operation
        @(negedge clk);
        Op = 2'b01; OperandA = 32'hFFFFFFFF; OperandB = 32'hFFFFFFFF; Start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        repeat (12) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset busy", 64'(Busy), 64'd0);
        check("midreset done", 64'(Done), 64'd0);
        check("midreset hi", 64'(Hi), 64'd0);
        check("midreset lo", 64'(Lo), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done) done_cnt++;
        end
        check("midreset no_done", 64'(done_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
